// File: rtl/ctrl_bus.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ctrl_bus
//  Description : Serial DCTRL bus master. Sends 10-bit characters (start 0,
//                8 data bits LSB first, stop 1), one bit per phase strobe.
//                Reads turn the bus around and wait for a 3-character reply.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_bus #(
    parameter int NCH          = 1,
    parameter int TURN_BITS    = 5,
    parameter int TIMEOUT_BITS = 50,
    localparam int LW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            phase_i,
    input  logic            req_i,
    input  logic [1:0]      op_i,
    input  logic [7:0]      opcode_i,
    input  logic [7:0]      chipid_i,
    input  logic [15:0]     addr_i,
    input  logic [15:0]     data_i,
    input  logic [LW-1:0]   lane_i,
    input  logic            bcast_i,
    output logic            ack_o,
    output logic [15:0]     data_o,
    output logic [7:0]      chipid_o,
    output logic            err_o,
    output logic            timeout_o,
    output logic            busy_o,
    output logic [15:0]     nerr_o,
    input  logic [NCH-1:0]  dctrl_i,
    output logic [NCH-1:0]  dctrl_o,
    output logic [NCH-1:0]  dctrl_oe_o
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_TX   = 3'd2;
    localparam logic [2:0] c_TURN = 3'd3;
    localparam logic [2:0] c_HUNT = 3'd4;
    localparam logic [2:0] c_RX   = 3'd5;
    localparam logic [2:0] c_TAIL = 3'd6;
    localparam logic [2:0] c_DONE = 3'd7;

    localparam logic [7:0] c_TURN_LAST = 8'(TURN_BITS - 1);
    localparam logic [7:0] c_TO_LAST   = 8'(TIMEOUT_BITS - 1);
    localparam logic [7:0] c_RX_LAST   = 8'd29;

    logic [2:0]     r_state;
    logic [2:0]     w_state_next;
    logic [59:0]    r_frame;
    logic [7:0]     r_nbits;
    logic [7:0]     r_cnt;
    logic           r_is_read;
    logic [7:0]     r_chip;
    logic [NCH-1:0] r_mask;
    logic           r_bit;
    logic           r_oe;
    logic [28:0]    r_rx;
    logic           r_err;
    logic           r_timeout;
    logic [15:0]    r_data;
    logic [7:0]     r_chipid;
    logic [15:0]    r_nerr;

    logic [NCH-1:0] w_lane_hot;
    logic [59:0]    w_frame;
    logic           w_rx_bit;
    logic [29:0]    w_rx_next;
    logic           w_rx_ok;
    logic [15:0]    w_nerr_inc;

    function automatic logic [9:0] f_char(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Whole write frame; commands and reads simply stop shifting earlier.
    assign w_frame = {f_char(data_i[15:8]), f_char(data_i[7:0]),
                      f_char(addr_i[15:8]), f_char(addr_i[7:0]),
                      f_char(chipid_i), f_char(opcode_i)};

    // An out-of-range lane selects nothing and therefore reads as idle-high.
    assign w_rx_bit   = &(dctrl_i | ~r_mask);
    assign w_rx_next  = {w_rx_bit, r_rx};
    assign w_rx_ok    = !w_rx_next[0]  && w_rx_next[9]  &&
                        !w_rx_next[10] && w_rx_next[19] &&
                        !w_rx_next[20] && w_rx_next[29] &&
                        (w_rx_next[8:1] == r_chip);
    assign w_nerr_inc = (r_nerr == 16'hFFFF) ? r_nerr : r_nerr + 16'd1;

    assign busy_o     = (r_state != c_IDLE);
    assign ack_o      = (r_state == c_DONE);
    assign err_o      = r_err;
    assign timeout_o  = r_timeout;
    assign data_o     = r_data;
    assign chipid_o   = r_chipid;
    assign nerr_o     = r_nerr;
    assign dctrl_o    = ~r_mask | {NCH{r_bit}};
    assign dctrl_oe_o = ~r_mask | {NCH{r_oe}};

    // One-hot decode of the requested lane.
    always_comb begin
        w_lane_hot = '0;
        for (int i = 0; i < NCH; i++) begin
            w_lane_hot[i] = (lane_i == LW'(i));
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode; every bus step advances only on a phase strobe.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (req_i) w_state_next = (op_i == 2'd3) ? c_DONE : c_LOAD;
            c_LOAD: if (phase_i) w_state_next = c_TX;
            c_TX:   if (phase_i && r_cnt == r_nbits)
                        w_state_next = r_is_read ? c_TURN : c_DONE;
            c_TURN: if (phase_i && r_cnt == c_TURN_LAST) w_state_next = c_HUNT;
            c_HUNT: if (phase_i) begin
                        if (!w_rx_bit)                w_state_next = c_RX;
                        else if (r_cnt == c_TO_LAST)  w_state_next = c_TAIL;
                    end
            c_RX:   if (phase_i && r_cnt == c_RX_LAST) w_state_next = c_TAIL;
            c_TAIL: if (phase_i && r_cnt == c_TURN_LAST) w_state_next = c_DONE;
            c_DONE: if (!req_i) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Datapath: request capture, serializer, receiver and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frame   <= '1;
            r_nbits   <= '0;
            r_cnt     <= '0;
            r_is_read <= 1'b0;
            r_chip    <= '0;
            r_mask    <= '0;
            r_bit     <= 1'b1;
            r_oe      <= 1'b1;
            r_rx      <= '1;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_data    <= 16'hFFFF;
            r_chipid  <= 8'hFF;
            r_nerr    <= '0;
        end else begin
            case (r_state)
                c_IDLE: if (req_i) begin
                    r_frame   <= w_frame;
                    r_chip    <= chipid_i;
                    r_is_read <= (op_i == 2'd2);
                    r_nbits   <= (op_i == 2'd0) ? 8'd10 : (op_i == 2'd1) ? 8'd60 : 8'd40;
                    r_mask    <= (op_i == 2'd2 || !bcast_i) ? w_lane_hot : '1;
                    r_cnt     <= '0;
                    r_timeout <= 1'b0;
                    r_err     <= (op_i == 2'd3);
                    if (op_i == 2'd3) r_nerr <= w_nerr_inc;
                end
                c_LOAD: if (phase_i) begin
                    r_bit   <= r_frame[0];
                    r_frame <= {1'b1, r_frame[59:1]};
                    r_cnt   <= 8'd1;
                end
                c_TX: if (phase_i) begin
                    if (r_cnt == r_nbits) begin
                        r_bit <= 1'b1;
                        r_cnt <= '0;
                    end else begin
                        r_bit   <= r_frame[0];
                        r_frame <= {1'b1, r_frame[59:1]};
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                c_TURN: if (phase_i) begin
                    if (r_cnt == c_TURN_LAST) begin
                        r_oe  <= 1'b0;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_HUNT: if (phase_i) begin
                    if (!w_rx_bit) begin
                        r_rx  <= w_rx_next[29:1];
                        r_cnt <= 8'd1;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_err     <= 1'b1;
                        r_data    <= 16'hFFFF;
                        r_nerr    <= w_nerr_inc;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_RX: if (phase_i) begin
                    r_rx <= w_rx_next[29:1];
                    if (r_cnt == c_RX_LAST) begin
                        r_chipid <= w_rx_next[8:1];
                        r_data   <= {w_rx_next[28:21], w_rx_next[18:11]};
                        if (!w_rx_ok) begin
                            r_err  <= 1'b1;
                            r_nerr <= w_nerr_inc;
                        end
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_TAIL: if (phase_i) begin
                    if (r_cnt == c_TURN_LAST) begin
                        r_oe  <= 1'b1;
                        r_bit <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ctrl_bus.md
CTRL_BUS -- requirements
Module: ctrl_bus

Interface
REQ-001 SHALL have parameter NCH, default 1: number of DCTRL lanes (1..16).
REQ-002 SHALL have parameter TURN_BITS, default 5: bit periods of bus turnaround before release and after reception (1..31).
REQ-003 SHALL have parameter TIMEOUT_BITS, default 50: max bit periods to wait for a read-response start bit (1..255).
REQ-004 SHALL have port clk_i  input  1  the single clock for the block.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port phase_i  input  1  bit strobe; one serial bit per clk_i cycle with phase_i=1.
REQ-007 SHALL have port req_i  input  1  level request; held high until ack_o is seen.
REQ-008 SHALL have port op_i  input  2  0=command, 1=write, 2=read, 3=illegal.
REQ-009 SHALL have ports opcode_i/chipid_i  input  8 each, and addr_i/data_i  input  16 each: transaction fields.
REQ-010 SHALL have port lane_i  input  max(1,clog2(NCH))  target lane index.
REQ-011 SHALL have port bcast_i  input  1  command/write driven on all lanes.
REQ-012 SHALL have port ack_o  output  1  transaction complete.
REQ-013 SHALL have ports data_o  output  16 (read data) and chipid_o  output  8 (received chip ID).
REQ-014 SHALL have ports err_o, timeout_o, busy_o  output  1 each.
REQ-015 SHALL have port nerr_o  output  16  error count.
REQ-016 SHALL have ports dctrl_i  input  NCH, dctrl_o  output  NCH, dctrl_oe_o  output  NCH.

Function
REQ-017 Character SHALL be 10 bits on the wire: start 0, 8 data bits LSB first, stop 1.
REQ-018 Command SHALL send opcode (10 bits); write SHALL send opcode, chipid, addr[7:0], addr[15:8], data[7:0], data[15:8] (60 bits); read SHALL send opcode, chipid, addr[7:0], addr[15:8] (40 bits).
REQ-019 FSM states SHALL be IDLE, LOAD, TX, TURN, HUNT, RX, TAIL, DONE.
REQ-020 IDLE: busy_o=0; on req_i=1, capture all inputs, clear err_o/timeout_o, go to LOAD; op_i=3 goes directly to DONE with err_o=1 and nerr_o+1.
REQ-021 LOAD: on phase_i, load the shift register, drive the first bit, enter TX; no bit is skipped or duplicated.
REQ-022 TX: shift one bit per phase_i; after the last bit, command/write go to DONE and read goes to TURN.
REQ-023 TURN: drive 1 with OE=1 for TURN_BITS phases, then release OE on the selected lane and go to HUNT.
REQ-024 HUNT: sample dctrl_i[lane] each phase; a 0 starts RX with that bit as bit 0; after TIMEOUT_BITS phases without a 0, set timeout_o=1, err_o=1, data_o=16'hFFFF, nerr_o+1, go to TAIL.
REQ-025 RX: shift in 30 bits (chipid, data lo, data hi); then check all start=0, stop=1 and chipid match; set err_o=1 and nerr_o+1 on any mismatch; always update data_o/chipid_o; go to TAIL.
REQ-026 TAIL: keep OE released for TURN_BITS phases, then re-drive OE=1, dctrl_o=1 and go to DONE.
REQ-027 DONE: ack_o=1 while req_i=1; return to IDLE when req_i=0; ack_o SHALL drop in the cycle after req_i falls.
REQ-028 Lanes not driven by the current transaction (unselected, or all except lane_i when bcast_i=0) SHALL hold dctrl_o=1, dctrl_oe_o=1.
REQ-029 For reads, bcast_i SHALL be ignored.
REQ-030 busy_o SHALL be 1 in every state except IDLE.
REQ-031 Input changes while busy_o=1 SHALL have no effect.
REQ-032 nerr_o SHALL saturate at 16'hFFFF.
REQ-033 err_o, timeout_o, data_o and chipid_o SHALL hold their values until the next accepted request.

Reset
REQ-034 While rst_i=1 on a clock edge, state SHALL be IDLE, ack_o/busy_o/err_o/timeout_o=0, nerr_o=0, data_o=16'hFFFF, chipid_o=8'hFF, dctrl_o and dctrl_oe_o all 1.
REQ-035 Reset mid-transaction SHALL abort immediately with no further bus activity.

Verification
REQ-036 NCH=2, phase every 4 clk; command opcode 8'hB1 -> lane 0 shows 0,1,0,0,0,1,1,0,1,1; ack_o after 10 phases; lane 1 idle high.
REQ-037 Write chip 8'h10, addr 16'h0203, data 16'hABCD, bcast_i=1 -> identical 60-bit frame on both lanes, OE=1 throughout, nerr_o unchanged.
REQ-038 Read on lane 1; model replies after 12 phases with chip 8'h10 and data 16'h1234 -> data_o=16'h1234, chipid_o=8'h10, err_o=0, OE released exactly from phase 46 until 5 phases after the last RX bit.
REQ-039 Read with no reply -> timeout_o=1, err_o=1, data_o=16'hFFFF, nerr_o=1, ack_o after 40+5+50+5 phases.
REQ-040 Reply with a bad stop bit; then op_i=3; then rst_i pulse during TX -> nerr_o=1, then 2; after reset, all outputs at REQ-034 values the next cycle.
